// File: rtl/matmul_nxn_axis.sv
// NxN integer matrix multiplier on AXI-Stream: loads A then B row-major,
// computes C = A x B one element per cycle, streams C out with backpressure.
module matmul_nxn_axis #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pN          = 4,
  parameter int unsigned pSIGNED     = 0
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   keep_a,
  output logic                   busy,
  output logic                   err_tlast
);

  localparam int unsigned DW = pDATA_WIDTH;
  localparam int unsigned NN = pN * pN;
  localparam int unsigned IW = $clog2(NN);
  localparam int unsigned RW = $clog2(pN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
  localparam logic [RW-1:0] LAST_RC  = RW'(pN - 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, OUT} state_t;

  state_t        state;
  logic [DW-1:0] a_mem [NN];
  logic [DW-1:0] b_mem [NN];
  logic [DW-1:0] c_mem [NN];
  logic [IW-1:0] idx;
  logic [IW-1:0] out_idx;
  logic [RW-1:0] row;
  logic [RW-1:0] col;
  logic          a_valid;
  logic [DW-1:0] dot_c;
  logic          beat_c;

  assign beat_c = ss_tvalid & ss_tready;

  // Dot product of A row `row` and B column `col`. Only the low DW bits of
  // each product survive truncation, and those do not depend on sign
  // extension, so DW-wide products give the full-precision result mod 2^DW.
  always_comb begin
    logic [IW-1:0] ai;
    logic [IW-1:0] bi;
    dot_c = '0;
    ai    = '0;
    bi    = '0;
    for (int j = 0; j < int'(pN); j++) begin
      ai = IW'(row) * IW'(pN) + IW'(j);
      bi = IW'(j) * IW'(pN) + IW'(col);
      if (pSIGNED != 0)
        dot_c = dot_c + DW'($signed(a_mem[ai]) * $signed(b_mem[bi]));
      else
        dot_c = dot_c + DW'(a_mem[ai] * b_mem[bi]);
    end
  end

  // Control FSM, storage and registered stream outputs.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_idx   <= '0;
      row       <= '0;
      col       <= '0;
      a_valid   <= 1'b0;
      ss_tready <= 1'b0;
      sm_tvalid <= 1'b0;
      sm_tdata  <= '0;
      sm_tlast  <= 1'b0;
      busy      <= 1'b0;
      err_tlast <= 1'b0;
      for (int i = 0; i < int'(NN); i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
        c_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (ss_tvalid) begin
            ss_tready <= 1'b1;
            busy      <= 1'b1;
            state     <= (keep_a && a_valid) ? LOAD_B : LOAD_A;
          end
        end

        LOAD_A: begin
          if (beat_c) begin
            a_mem[idx] <= ss_tdata;
            if (idx == LAST_IDX) begin
              idx     <= '0;
              a_valid <= 1'b1;
              state   <= LOAD_B;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        LOAD_B: begin
          if (beat_c) begin
            b_mem[idx] <= ss_tdata;
            if (ss_tlast != (idx == LAST_IDX))
              err_tlast <= 1'b1;
            if (idx == LAST_IDX) begin
              idx       <= '0;
              row       <= '0;
              col       <= '0;
              ss_tready <= 1'b0;
              state     <= COMPUTE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        // idx doubles as the row-major C index while row/col address A and B
        COMPUTE: begin
          c_mem[idx] <= dot_c;
          if (col == LAST_RC) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + RW'(1);
          end
          if (idx == LAST_IDX) begin
            idx     <= '0;
            out_idx <= '0;
            state   <= OUT;
          end else begin
            idx <= idx + IW'(1);
          end
        end

        OUT: begin
          if (!sm_tvalid) begin
            sm_tvalid <= 1'b1;
            sm_tdata  <= c_mem[out_idx];
            sm_tlast  <= (out_idx == LAST_IDX);
          end else if (sm_tready) begin
            if (sm_tlast) begin
              sm_tvalid <= 1'b0;
              sm_tlast  <= 1'b0;
              out_idx   <= '0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              out_idx  <= out_idx + IW'(1);
              sm_tdata <= c_mem[out_idx + IW'(1)];
              sm_tlast <= ((out_idx + IW'(1)) == LAST_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
